// File: rtl/phj_join_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : phj_join_controller                                         |
// | Purpose  : Sequences one hash-table instance through clear, build and  |
// |            probe phases for every partition of a partitioned hash      |
// |            join. Gates the build/probe stream handshakes per phase,    |
// |            waits out table init and pipeline drain, and counts build   |
// |            tuples, probe tuples and matches for the current partition. |
// | Ports    : clk/reset            clock, synchronous active-high reset   |
// |            start/num_partitions join launch, partition count           |
// |            busy/done/part_idx   join status                            |
// |            bld_* / prb_*        partitioner build / probe streams      |
// |            ht_*                 hash-table control and requests        |
// |            *_count, stray_match per-partition statistics               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module phj_join_controller #(
    parameter int ROW_BITS    = 3,
    parameter int PART_BITS   = 8,
    parameter int BUILD_DRAIN = 2,   // must be >= 1
    parameter int PROBE_DRAIN = 2    // must be >= 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PART_BITS-1:0] num_partitions,
    output logic                 busy,
    output logic                 done,
    output logic [PART_BITS-1:0] part_idx,
    input  logic                 bld_valid,
    output logic                 bld_ready,
    input  logic                 bld_last,
    input  logic [63:0]          bld_tuple,
    input  logic [31:0]          bld_hash,
    input  logic                 prb_valid,
    output logic                 prb_ready,
    input  logic                 prb_last,
    input  logic [63:0]          prb_tuple,
    input  logic [31:0]          prb_hash,
    output logic                 ht_clear,
    input  logic                 ht_build_ready,
    output logic                 ht_valid_build,
    output logic [63:0]          ht_tuple_build,
    output logic [31:0]          ht_hash_build,
    output logic                 ht_start_probing,
    output logic                 ht_valid_probe,
    output logic [63:0]          ht_tuple_probe,
    output logic [31:0]          ht_hash_probe,
    input  logic                 ht_output_valid,
    output logic [31:0]          build_count,
    output logic [31:0]          probe_count,
    output logic [31:0]          match_count,
    output logic                 stray_match
);

    localparam int c_CLEAR_CYCLES = (1 << ROW_BITS) + 1;
    localparam int c_DRAIN_MAX    = (BUILD_DRAIN > PROBE_DRAIN) ? BUILD_DRAIN : PROBE_DRAIN;
    localparam int c_WAIT_MAX     = (c_CLEAR_CYCLES > c_DRAIN_MAX) ? c_CLEAR_CYCLES : c_DRAIN_MAX;
    localparam int c_WAIT_W       = $clog2(c_WAIT_MAX + 1);

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_CLEAR       = 3'd1;
    localparam logic [2:0] c_ST_BUILD       = 3'd2;
    localparam logic [2:0] c_ST_BUILD_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_PROBE       = 3'd4;
    localparam logic [2:0] c_ST_PROBE_DRAIN = 3'd5;
    localparam logic [2:0] c_ST_DONE        = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [PART_BITS-1:0] r_num_parts;
    logic [PART_BITS-1:0] r_part_idx;
    logic [31:0]          r_build_count;
    logic [31:0]          r_probe_count;
    logic [31:0]          r_match_count;
    logic                 r_stray;

    logic w_bld_xfer;
    logic w_prb_xfer;
    logic w_probe_window;
    logic w_last_part;

    assign w_bld_xfer     = (r_state == c_ST_BUILD) && bld_valid && ht_build_ready;
    assign w_prb_xfer     = (r_state == c_ST_PROBE) && prb_valid;
    assign w_probe_window = (r_state == c_ST_PROBE) || (r_state == c_ST_PROBE_DRAIN);
    assign w_last_part    = (r_part_idx == (r_num_parts - PART_BITS'(1)));

    assign part_idx    = r_part_idx;
    assign build_count = r_build_count;
    assign probe_count = r_probe_count;
    assign match_count = r_match_count;
    assign stray_match = r_stray;

    // Next-state and phase-gated outputs. Stream fields are forced to zero
    // outside their phase so the table never sees stale request data.
    always_comb begin
        w_state_next     = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        ht_clear         = 1'b0;
        bld_ready        = 1'b0;
        prb_ready        = 1'b0;
        ht_start_probing = 1'b0;
        ht_valid_build   = 1'b0;
        ht_valid_probe   = 1'b0;
        ht_tuple_build   = '0;
        ht_hash_build    = '0;
        ht_tuple_probe   = '0;
        ht_hash_probe    = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_partitions != '0) ? c_ST_CLEAR : c_ST_DONE;
                end
            end
            c_ST_CLEAR: begin
                busy     = 1'b1;
                ht_clear = (r_wait == '0);
                if (r_wait == c_WAIT_W'(c_CLEAR_CYCLES - 1)) begin
                    w_state_next = c_ST_BUILD;
                end
            end
            c_ST_BUILD: begin
                busy           = 1'b1;
                bld_ready      = ht_build_ready;
                ht_valid_build = bld_valid && ht_build_ready;
                ht_tuple_build = bld_tuple;
                ht_hash_build  = bld_hash;
                if (w_bld_xfer && bld_last) begin
                    w_state_next = c_ST_BUILD_DRAIN;
                end
            end
            c_ST_BUILD_DRAIN: begin
                busy = 1'b1;
                if (r_wait == c_WAIT_W'(BUILD_DRAIN - 1)) begin
                    w_state_next = c_ST_PROBE;
                end
            end
            c_ST_PROBE: begin
                busy             = 1'b1;
                prb_ready        = 1'b1;
                ht_start_probing = 1'b1;
                ht_valid_probe   = prb_valid;
                ht_tuple_probe   = prb_tuple;
                ht_hash_probe    = prb_hash;
                if (w_prb_xfer && prb_last) begin
                    w_state_next = c_ST_PROBE_DRAIN;
                end
            end
            c_ST_PROBE_DRAIN: begin
                busy             = 1'b1;
                ht_start_probing = 1'b1;
                if (r_wait == c_WAIT_W'(PROBE_DRAIN - 1)) begin
                    w_state_next = w_last_part ? c_ST_DONE : c_ST_CLEAR;
                end
            end
            c_ST_DONE: begin
                done         = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait        <= '0;
            r_num_parts   <= '0;
            r_part_idx    <= '0;
            r_build_count <= '0;
            r_probe_count <= '0;
            r_match_count <= '0;
            r_stray       <= 1'b0;
        end else begin
            // Phase-local cycle counter: restarts on every state change.
            if (w_state_next != r_state) begin
                r_wait <= '0;
            end else if (r_wait != '1) begin
                r_wait <= r_wait + 1'b1;
            end

            if ((r_state == c_ST_IDLE) && start) begin
                r_num_parts <= num_partitions;
                r_part_idx  <= '0;
            end else if ((r_state == c_ST_PROBE_DRAIN) && (w_state_next == c_ST_CLEAR)) begin
                r_part_idx <= r_part_idx + PART_BITS'(1);
            end

            // Counters hold their last partition's values until the next
            // clear phase completes, then restart for the new partition.
            if ((r_state == c_ST_CLEAR) && (w_state_next == c_ST_BUILD)) begin
                r_build_count <= '0;
                r_probe_count <= '0;
                r_match_count <= '0;
            end else begin
                if (w_bld_xfer && (r_build_count != '1)) begin
                    r_build_count <= r_build_count + 32'd1;
                end
                if (w_prb_xfer && (r_probe_count != '1)) begin
                    r_probe_count <= r_probe_count + 32'd1;
                end
                if (ht_output_valid && w_probe_window && (r_match_count != '1)) begin
                    r_match_count <= r_match_count + 32'd1;
                end
            end

            if (ht_output_valid && !w_probe_window) begin
                r_stray <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phj_join_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_phj_join_controller                                      |
// | Purpose  : Randomized self-checking bench for phj_join_controller.     |
// |            A phase-timeline reference model predicts every control     |
// |            output, counter and pulse count per cycle.                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_phj_join_controller;

    localparam int ROW_BITS    = 3;
    localparam int PART_BITS   = 8;
    localparam int BUILD_DRAIN = 2;
    localparam int PROBE_DRAIN = 2;
    localparam int CLEAR_LEN   = (1 << ROW_BITS) + 1;
    localparam int BUDGET      = 3000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [PART_BITS-1:0] num_partitions;
    logic                 busy, done;
    logic [PART_BITS-1:0] part_idx;
    logic                 bld_valid, bld_ready, bld_last;
    logic [63:0]          bld_tuple;
    logic [31:0]          bld_hash;
    logic                 prb_valid, prb_ready, prb_last;
    logic [63:0]          prb_tuple;
    logic [31:0]          prb_hash;
    logic                 ht_clear, ht_build_ready, ht_valid_build;
    logic [63:0]          ht_tuple_build;
    logic [31:0]          ht_hash_build;
    logic                 ht_start_probing, ht_valid_probe;
    logic [63:0]          ht_tuple_probe;
    logic [31:0]          ht_hash_probe;
    logic                 ht_output_valid;
    logic [31:0]          build_count, probe_count, match_count;
    logic                 stray_match;

    phj_join_controller #(
        .ROW_BITS    (ROW_BITS),
        .PART_BITS   (PART_BITS),
        .BUILD_DRAIN (BUILD_DRAIN),
        .PROBE_DRAIN (PROBE_DRAIN)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .num_partitions   (num_partitions),
        .busy             (busy),
        .done             (done),
        .part_idx         (part_idx),
        .bld_valid        (bld_valid),
        .bld_ready        (bld_ready),
        .bld_last         (bld_last),
        .bld_tuple        (bld_tuple),
        .bld_hash         (bld_hash),
        .prb_valid        (prb_valid),
        .prb_ready        (prb_ready),
        .prb_last         (prb_last),
        .prb_tuple        (prb_tuple),
        .prb_hash         (prb_hash),
        .ht_clear         (ht_clear),
        .ht_build_ready   (ht_build_ready),
        .ht_valid_build   (ht_valid_build),
        .ht_tuple_build   (ht_tuple_build),
        .ht_hash_build    (ht_hash_build),
        .ht_start_probing (ht_start_probing),
        .ht_valid_probe   (ht_valid_probe),
        .ht_tuple_probe   (ht_tuple_probe),
        .ht_hash_probe    (ht_hash_probe),
        .ht_output_valid  (ht_output_valid),
        .build_count      (build_count),
        .probe_count      (probe_count),
        .match_count      (match_count),
        .stray_match      (stray_match)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: phase timeline ----------------
    typedef enum int {P_IDLE, P_CLEAR, P_BUILD, P_BDRAIN, P_PROBE, P_PDRAIN, P_DONE} phase_t;

    phase_t         m_phase;
    int             m_phase_start;
    int             cyc;
    logic [7:0]     m_parts, m_part;
    int unsigned    m_bcnt, m_pcnt, m_mcnt;
    bit             m_stray;
    int             m_clears;

    // stream state (partitioner side)
    int             j_n;
    int             nb[8], np[8];
    int             bpart, bidx, ppart, pidx;
    logic [63:0]    cur_bt, cur_pt;
    logic [31:0]    cur_bh, cur_ph;
    bit             do_abort, aborted, allow_stray, toggle_rdy;
    int             obs_clears, obs_done;

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic enter(input phase_t p);
        m_phase       = p;
        m_phase_start = cyc + 1;
        if (p == P_CLEAR) m_clears++;
    endtask

    task automatic one_cycle();
        logic [8:0] exp_ctrl, obs_ctrl;
        bit probe_win, bx, px;
        int elapsed;
        #4;
        probe_win = (m_phase == P_PROBE) || (m_phase == P_PDRAIN);
        bx = (m_phase == P_BUILD) && bld_valid && ht_build_ready;
        px = (m_phase == P_PROBE) && prb_valid;
        exp_ctrl = {(m_phase != P_IDLE) && (m_phase != P_DONE), m_phase == P_DONE,
                    (m_phase == P_CLEAR) && (cyc == m_phase_start),
                    (m_phase == P_BUILD) && ht_build_ready, m_phase == P_PROBE,
                    probe_win, bx, px, m_stray};
        obs_ctrl = {busy, done, ht_clear, bld_ready, prb_ready, ht_start_probing,
                    ht_valid_build, ht_valid_probe, stray_match};
        check("ctrl{busy,done,clr,brdy,prdy,sprb,vb,vp,stray}", 64'(obs_ctrl), 64'(exp_ctrl));
        check("part_idx", 64'(part_idx), 64'(m_part));
        if (m_phase != P_CLEAR) begin
            check("build_count", 64'(build_count), 64'(m_bcnt));
            check("probe_count", 64'(probe_count), 64'(m_pcnt));
            check("match_count", 64'(match_count), 64'(m_mcnt));
        end
        if (bx) begin
            check("ht_tuple_build", ht_tuple_build, bld_tuple);
            check("ht_hash_build", 64'(ht_hash_build), 64'(bld_hash));
        end
        if (px) begin
            check("ht_tuple_probe", ht_tuple_probe, prb_tuple);
            check("ht_hash_probe", 64'(ht_hash_probe), 64'(prb_hash));
        end
        if (ht_clear) obs_clears++;
        if (done) obs_done++;

        // advance model to the next cycle
        if (reset) begin
            m_phase = P_IDLE; m_part = '0; m_stray = 0;
            m_bcnt = 0; m_pcnt = 0; m_mcnt = 0;
        end else begin
            if (ht_output_valid) begin
                if (probe_win) m_mcnt = sat_inc(m_mcnt);
                else m_stray = 1;
            end
            if (bx) begin
                m_bcnt = sat_inc(m_bcnt);
                bidx++;
                if (bidx == nb[bpart]) begin bidx = 0; bpart++; end
                cur_bt = {$urandom, $urandom}; cur_bh = $urandom;
            end
            if (px) begin
                m_pcnt = sat_inc(m_pcnt);
                pidx++;
                if (pidx == np[ppart]) begin pidx = 0; ppart++; end
                cur_pt = {$urandom, $urandom}; cur_ph = $urandom;
            end
            elapsed = cyc - m_phase_start + 1;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_part = '0;
                    if (num_partitions != '0) begin
                        m_parts = num_partitions;
                        enter(P_CLEAR);
                    end else begin
                        enter(P_DONE);
                    end
                end
                P_CLEAR: if (elapsed == CLEAR_LEN) begin
                    m_bcnt = 0; m_pcnt = 0; m_mcnt = 0;
                    enter(P_BUILD);
                end
                P_BUILD:  if (bx && bld_last) enter(P_BDRAIN);
                P_BDRAIN: if (elapsed == BUILD_DRAIN) enter(P_PROBE);
                P_PROBE:  if (px && prb_last) enter(P_PDRAIN);
                P_PDRAIN: if (elapsed == PROBE_DRAIN) begin
                    if (m_part == m_parts - 8'd1) enter(P_DONE);
                    else begin m_part = m_part + 8'd1; enter(P_CLEAR); end
                end
                P_DONE:   enter(P_IDLE);
                default:  enter(P_IDLE);
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive the partitioner streams and table inputs for the current cycle.
    task automatic drive();
        bld_valid = 1'b0; bld_last = 1'b0;
        if (bpart < j_n) begin
            bld_valid = ($urandom_range(0, 9) < 7);
            bld_last  = (bidx == nb[bpart] - 1);
        end
        bld_tuple = cur_bt; bld_hash = cur_bh;
        prb_valid = 1'b0; prb_last = 1'b0;
        if (ppart < j_n) begin
            prb_valid = ($urandom_range(0, 9) < 7);
            prb_last  = (pidx == np[ppart] - 1);
        end
        prb_tuple = cur_pt; prb_hash = cur_ph;
        ht_build_ready = toggle_rdy ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
        num_partitions = PART_BITS'($urandom_range(0, 255));
        // stray starts: always one at the first BUILD cycle, otherwise sparse
        start = (m_phase != P_IDLE) &&
                (((m_phase == P_BUILD) && (cyc == m_phase_start)) || ($urandom_range(0, 19) == 0));
        if ((m_phase == P_PROBE) || (m_phase == P_PDRAIN))
            ht_output_valid = ($urandom_range(0, 9) < 4);
        else if (allow_stray && (m_phase == P_BUILD) && (cyc == m_phase_start))
            ht_output_valid = 1'b1;
        else
            ht_output_valid = allow_stray && ($urandom_range(0, 19) == 0);
        reset = 1'b0;
        if (do_abort && !aborted && (m_phase == P_PROBE) && (m_pcnt >= 1)) begin
            reset   = 1'b1;
            aborted = 1;
        end
    endtask

    task automatic quiet_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            start = 0; bld_valid = 0; prb_valid = 0; bld_last = 0; prb_last = 0;
            ht_output_valid = 0; reset = 0; ht_build_ready = 0;
            num_partitions = PART_BITS'($urandom_range(0, 255));
            one_cycle();
        end
    endtask

    task automatic run_join(input int n, input bit abort_i, input bit stray_i, input bit toggle_i);
        int guard;
        j_n = n; do_abort = abort_i; aborted = 0; allow_stray = stray_i; toggle_rdy = toggle_i;
        for (int i = 0; i < 8; i++) begin
            nb[i] = $urandom_range(1, 5);
            np[i] = $urandom_range(1, 4);
        end
        bpart = 0; bidx = 0; ppart = 0; pidx = 0;
        obs_clears = 0; obs_done = 0; m_clears = 0;
        drive();
        start = 1'b1;
        num_partitions = PART_BITS'(n);
        one_cycle();
        guard = 0;
        while ((m_phase != P_IDLE) && (guard < BUDGET)) begin
            drive();
            one_cycle();
            guard++;
        end
        check("join_within_budget", 64'(guard < BUDGET), 64'd1);
        quiet_cycles(2);
        check("done_pulses", 64'(obs_done), aborted ? 64'd0 : 64'd1);
        check("clear_pulses", 64'(obs_clears), 64'(m_clears));
    endtask

    initial begin
        reset = 1; start = 0; num_partitions = '0;
        bld_valid = 0; bld_last = 0; bld_tuple = '0; bld_hash = '0;
        prb_valid = 0; prb_last = 0; prb_tuple = '0; prb_hash = '0;
        ht_build_ready = 0; ht_output_valid = 0;
        cur_bt = {$urandom, $urandom}; cur_bh = $urandom;
        cur_pt = {$urandom, $urandom}; cur_ph = $urandom;
        j_n = 0; allow_stray = 0; do_abort = 0; aborted = 0; toggle_rdy = 0;
        m_phase = P_IDLE; m_phase_start = 0; m_parts = '0; m_part = '0;
        m_bcnt = 0; m_pcnt = 0; m_mcnt = 0; m_stray = 0; m_clears = 0;
        obs_clears = 0; obs_done = 0; cyc = 0;
        @(posedge clk); @(posedge clk); #1;
        // one checked cycle still in reset: all outputs must read zero
        reset = 1;
        one_cycle();
        quiet_cycles(2);

        run_join(1, 0, 0, 0);   // single partition
        run_join(0, 0, 0, 0);   // zero partitions: bare done pulse
        run_join(1, 0, 0, 1);   // build backpressure toggling every cycle
        run_join(3, 0, 0, 0);   // multiple partitions
        run_join(2, 1, 0, 0);   // reset in the middle of PROBE
        run_join(2, 0, 0, 0);   // clean join after the abort
        run_join(2, 0, 1, 0);   // stray matches outside the probe window
        for (int k = 0; k < 8; k++) begin
            run_join($urandom_range(1, 4), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phj_join_controller.md
Name: phj_join_controller

Overview:
- Sequences one hash-table instance through clear, build and probe phases for each partition of a partitioned hash join.
- Sits between the partitioner output streams (build side, probe side) and the hash table.
- Gates valid/ready handshakes per phase, waits out table init and pipeline latency, and counts tuples and matches per partition.

Parameters:
- ROW_BITS, 3, hash-table row address width; clear wait = 2**ROW_BITS + 1 cycles.
- PART_BITS, 8, width of the partition index and count.
- BUILD_DRAIN, 2, cycles waited after the last build tuple so its read-modify-write completes.
- PROBE_DRAIN, 2, cycles waited after the last probe tuple so its match can emerge.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a join (ignored unless idle)
- num_partitions  in  PART_BITS  number of partitions, sampled on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when all partitions have finished
- part_idx  out  PART_BITS  index of the current partition
- bld_valid / bld_ready / bld_last  in / out / in  1 each  build stream handshake; last marks a partition's final tuple
- bld_tuple, bld_hash  in  64, 32  build tuple and its hash
- prb_valid / prb_ready / prb_last  in / out / in  1 each  probe stream handshake
- prb_tuple, prb_hash  in  64, 32  probe tuple and its hash
- ht_clear  out  1  one-cycle pulse that re-initialises the table
- ht_build_ready  in  1  table can accept a build tuple
- ht_valid_build, ht_tuple_build, ht_hash_build  out  1, 64, 32  build request to the table
- ht_start_probing  out  1  level signal, high during PROBE and PROBE_DRAIN
- ht_valid_probe, ht_tuple_probe, ht_hash_probe  out  1, 64, 32  probe request to the table
- ht_output_valid  in  1  table reports a match this cycle
- build_count, probe_count, match_count  out  32 each  counts for the current partition; saturate at 2^32-1
- stray_match  out  1  sticky flag: ht_output_valid seen outside the probe window

Behaviour:
- Reset value of every output is 0; state returns to IDLE; all counters clear. Reset mid-operation aborts immediately; partial table contents are don't-care because the next partition starts with CLEAR.
- States and transitions:
  - IDLE: on start with num_partitions != 0, go to CLEAR with part_idx=0. On start with num_partitions == 0, pulse done next cycle, no ht_clear. start while busy is ignored.
  - CLEAR: ht_clear is high in the first cycle only. Wait 2**ROW_BITS+1 cycles total, zero all three counters, then go to BUILD.
  - BUILD:
    - bld_ready = ht_build_ready; ht_valid_build = bld_valid & ht_build_ready.
    - Tuple and hash pass through combinationally.
    - Each transfer (bld_valid & bld_ready) increments build_count.
    - A transfer with bld_last goes to BUILD_DRAIN.
  - BUILD_DRAIN: hold for BUILD_DRAIN cycles with no requests, then go to PROBE.
  - PROBE:
    - prb_ready = 1; ht_valid_probe = prb_valid; fields pass through.
    - Each transfer increments probe_count.
    - A transfer with prb_last goes to PROBE_DRAIN.
  - PROBE_DRAIN: hold for PROBE_DRAIN cycles. Then:
    - if part_idx == num_partitions-1, go to DONE;
    - otherwise part_idx increments and go to CLEAR.
  - DONE: done=1 for one cycle, busy drops in the same cycle, go to IDLE.
- Ready gating: bld_ready is 0 outside BUILD; prb_ready is 0 outside PROBE. Tuples are never dropped or duplicated.
- Match counting: match_count increments on ht_output_valid in PROBE and PROBE_DRAIN. ht_output_valid in any other state sets stray_match; only reset clears it.
- Partition sizing: every partition has at least one build tuple and one probe tuple. Each stream's last tuple is itself a counted transfer.
- Sampling: num_partitions is latched on an accepted start; later input changes are ignored.
- Counter values hold after DONE until the next CLEAR.

Test Plan:
- Single partition, ROW_BITS=3: start, num_partitions=1; 3 build tuples (last on the 3rd), 2 probe tuples with 1 match -> ht_clear pulses once; bld_ready first high 9 cycles after CLEAR entry; build_count=3, probe_count=2, match_count=1; done pulses once.
- Backpressure: ht_build_ready toggles 1/0 every cycle during 4 build tuples -> exactly 4 ht_valid_build pulses, each coinciding with ht_build_ready=1; build_count=4.
- Multiple partitions: num_partitions=3 with 2 build + 2 probe tuples each -> part_idx steps 0,1,2; ht_clear pulses 3 times; prb_ready stays 0 during every BUILD; one done pulse.
- Edge starts: start with num_partitions=0 -> done pulse next cycle, no ht_clear, busy stays 0. A second start while in BUILD -> ignored, part_idx unchanged.
- Reset mid-PROBE: assert reset for one cycle -> all outputs 0, state IDLE. A following start runs a clean join with counters starting from 0.
- Stray match: ht_output_valid pulsed during BUILD -> stray_match=1 and match_count unchanged.
